stall_mem: RTL and testbench

STALL_MEM -- requirements
Module: stall_mem

---
 rtl/stall_mem_pkg.sv | 22 ++
 rtl/stall_mem_port.sv | 73 +++++++
 rtl/stall_mem.sv | 124 ++++++++++++
 tb/tb_stall_mem.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stall_mem_pkg.sv
// Shared definitions for the stall_mem dual-port wait-state memory model.
package stall_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } port_state_e;

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned WAIT_MAX  = (1 << CNT_W) - 1;
  localparam int unsigned DEF_BASE  = 32'h0000_1000;
  localparam int unsigned DEF_DEPTH = 4096;

  // Unsigned window test done in 64 bits so BASE+DEPTH never wraps.
  function automatic logic in_window(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] depth);
    return (addr >= base) && (addr < base + depth);
  endfunction

endpackage

// File: rtl/stall_mem_port.sv
// Per-port IDLE/WAIT/RESP sequencer with a programmable wait-state counter.
module stall_mem_port
  import stall_mem_pkg::*;
#(
  parameter int WAIT = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  output logic busy_o,
  output logic accept_o,
  output logic fire_o,
  output logic ack_o
);

  if (WAIT < 0 || WAIT > int'(WAIT_MAX)) begin : g_bad_wait
    $error("stall_mem_port: WAIT=%0d outside 0..%0d", WAIT, WAIT_MAX);
  end

  // The cycle right after the accept edge is the first wait cycle, so the
  // counter holds the remaining cycles (WAIT-1) and a zero-wait port goes
  // straight to RESP, giving ack in cycle WAIT+1 and one access per WAIT+1.
  localparam logic [CNT_W-1:0] LOAD = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;

  port_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers, cleared immediately on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, countdown and status decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fire_o   = 1'b0;
    busy_o   = (state_q == ST_WAIT);
    ack_o    = (state_q == ST_RESP);
    accept_o = req_i && !busy_o;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept_o) begin
          if (WAIT == 0) begin
            state_d = ST_RESP;
            fire_o  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          fire_o  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/stall_mem.sv
// Dual-port word store: port 0 read/write, port 1 read-only, each with its
// own wait-state sequencer. Same-edge p0 write / p1 read returns old data.
module stall_mem
  import stall_mem_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned BASE    = DEF_BASE,
  parameter int unsigned DEPTH   = DEF_DEPTH,
  parameter int          P0_WAIT = 1,
  parameter int          P1_WAIT = 0
) (
  input  logic              clk,
  input  logic              _reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_busy,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  output logic              p1_busy,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              p0_accept, p0_fire, p1_accept, p1_fire;
  logic [ADDR_W-1:0] p0_addr_q, p1_addr_q, p0_addr_eff, p1_addr_eff;
  logic              p0_we_q, p0_we_eff;
  logic [DATA_W-1:0] p0_wdata_q, p0_wdata_eff;
  logic              p0_ok, p1_ok;
  logic [IDX_W-1:0]  p0_idx, p1_idx;
  logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;
  logic              p0_err_q, p1_err_q;

  stall_mem_port #(.WAIT(P0_WAIT)) u_p0 (
    .clk_i    (clk),
    .rst_ni   (_reset),
    .req_i    (p0_req),
    .busy_o   (p0_busy),
    .accept_o (p0_accept),
    .fire_o   (p0_fire),
    .ack_o    (p0_ack)
  );

  stall_mem_port #(.WAIT(P1_WAIT)) u_p1 (
    .clk_i    (clk),
    .rst_ni   (_reset),
    .req_i    (p1_req),
    .busy_o   (p1_busy),
    .accept_o (p1_accept),
    .fire_o   (p1_fire),
    .ack_o    (p1_ack)
  );

  // Capture request fields on the accept edge.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      p0_addr_q  <= '0;
      p0_we_q    <= 1'b0;
      p0_wdata_q <= '0;
      p1_addr_q  <= '0;
    end else begin
      if (p0_accept) begin
        p0_addr_q  <= p0_addr;
        p0_we_q    <= p0_we;
        p0_wdata_q <= p0_wdata;
      end
      if (p1_accept) p1_addr_q <= p1_addr;
    end
  end

  // A zero-wait port performs its access on the accept edge itself, so the
  // live request fields are used whenever an accept is in progress.
  always_comb begin
    p0_addr_eff  = p0_accept ? p0_addr  : p0_addr_q;
    p0_we_eff    = p0_accept ? p0_we    : p0_we_q;
    p0_wdata_eff = p0_accept ? p0_wdata : p0_wdata_q;
    p1_addr_eff  = p1_accept ? p1_addr  : p1_addr_q;
    p0_ok        = in_window(64'(p0_addr_eff), 64'(BASE), 64'(DEPTH));
    p1_ok        = in_window(64'(p1_addr_eff), 64'(BASE), 64'(DEPTH));
    p0_idx       = IDX_W'(p0_addr_eff - ADDR_W'(BASE));
    p1_idx       = IDX_W'(p1_addr_eff - ADDR_W'(BASE));
  end

  // Store write from port 0; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (_reset && p0_fire && p0_we_eff && p0_ok) mem_q[p0_idx] <= p0_wdata_eff;
  end

  // Response registers, loaded on the edge each access is performed.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      p0_rdata_q <= '0;
      p0_err_q   <= 1'b0;
      p1_rdata_q <= '0;
      p1_err_q   <= 1'b0;
    end else begin
      if (p0_fire) begin
        p0_err_q <= !p0_ok;
        if (!p0_ok)          p0_rdata_q <= '0;
        else if (!p0_we_eff) p0_rdata_q <= mem_q[p0_idx];
      end
      if (p1_fire) begin
        p1_err_q   <= !p1_ok;
        p1_rdata_q <= p1_ok ? mem_q[p1_idx] : '0;
      end
    end
  end

  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;
  assign p0_err   = p0_ack & p0_err_q;
  assign p1_err   = p1_ack & p1_err_q;

endmodule

// File: tb/tb_stall_mem.sv
// Self-checking bench: three stall_mem instances with different wait states
// share one stimulus stream; a transaction-level model predicts every output.
module tb_stall_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0;
  logic [31:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0;

  logic        busy_s [3][2];
  logic        ack_s  [3][2];
  logic        err_s  [3][2];
  logic [31:0] rd_s   [3][2];

  int n_assert = 0;
  int n_fail   = 0;
  int e_n      = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    stall_mem #(
      .DATA_W  (32),
      .ADDR_W  (32),
      .BASE    (32'h1000),
      .DEPTH   (4096),
      .P0_WAIT (k + 1),
      .P1_WAIT ((k == 0) ? 0 : (k == 1) ? 2 : 5)
    ) u_dut (
      .clk      (clk),
      ._reset   (rst_n),
      .p0_req   (p0_req),
      .p0_we    (p0_we),
      .p0_addr  (p0_addr),
      .p0_wdata (p0_wdata),
      .p0_busy  (busy_s[k][0]),
      .p0_ack   (ack_s[k][0]),
      .p0_err   (err_s[k][0]),
      .p0_rdata (rd_s[k][0]),
      .p1_req   (p1_req),
      .p1_addr  (p1_addr),
      .p1_busy  (busy_s[k][1]),
      .p1_ack   (ack_s[k][1]),
      .p1_err   (err_s[k][1]),
      .p1_rdata (rd_s[k][1])
    );
  end

  // Reference model: each transaction is due WAIT cycles after its accept
  // edge; a port is busy until its due edge; reads see the store as it was
  // before any write performed on the same edge.
  bit          pend_m [3][2];
  int          due_m  [3][2];
  logic [31:0] addr_m [3][2];
  bit          we_m   [3][2];
  logic [31:0] wd_m   [3][2];
  bit          ack_m  [3][2];
  bit          err_m  [3][2];
  logic [31:0] rd_m   [3][2];
  logic [31:0] mem_m  [3][32];

  function automatic int wait_of(input int k, input int p);
    if (p == 0) return k + 1;
    return (k == 0) ? 0 : (k == 1) ? 2 : 5;
  endfunction

  function automatic logic [31:0] slot_addr(input int s);
    return (s < 16) ? 32'h1000 + 32'(s) : 32'h1FF0 + 32'(s - 16);
  endfunction

  function automatic int slot_of(input logic [31:0] a);
    return (a < 32'h1010) ? int'(a - 32'h1000) : int'(a - 32'h1FF0) + 16;
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 11);
    case (r)
      0:       return 32'h0000_0FFF;
      1:       return 32'h0000_2000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      default: return slot_addr(int'($urandom_range(0, 31)));
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 2; p++) begin
        pend_m[k][p] = 1'b0;
        ack_m[k][p]  = 1'b0;
        err_m[k][p]  = 1'b0;
        rd_m[k][p]   = '0;
      end
  endtask

  task automatic complete(input int k, input int p);
    logic [31:0] a;
    a = addr_m[k][p];
    pend_m[k][p] = 1'b0;
    ack_m[k][p]  = 1'b1;
    if (a < 32'h1000 || a > 32'h1FFF) begin
      err_m[k][p] = 1'b1;
      rd_m[k][p]  = '0;
    end else if (p == 0 && we_m[k][p]) begin
      mem_m[k][slot_of(a)] = wd_m[k][p];
    end else begin
      rd_m[k][p] = mem_m[k][slot_of(a)];
    end
  endtask

  task automatic model_edge(input int e);
    bit bsy [2];
    if (!rst_n) return;
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < 2; p++) begin
        bsy[p] = pend_m[k][p] && (due_m[k][p] >= e);
        ack_m[k][p] = 1'b0;
        err_m[k][p] = 1'b0;
      end
      if (p0_req && !bsy[0]) begin
        pend_m[k][0] = 1'b1;
        due_m[k][0]  = e + wait_of(k, 0);
        addr_m[k][0] = p0_addr;
        we_m[k][0]   = p0_we;
        wd_m[k][0]   = p0_wdata;
      end
      if (p1_req && !bsy[1]) begin
        pend_m[k][1] = 1'b1;
        due_m[k][1]  = e + wait_of(k, 1);
        addr_m[k][1] = p1_addr;
        we_m[k][1]   = 1'b0;
      end
      for (int p = 1; p >= 0; p--)
        if (pend_m[k][p] && due_m[k][p] == e) complete(k, p);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++)
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("d%0d.p%0d.busy", k, p), 32'(busy_s[k][p]),
            32'(pend_m[k][p] && due_m[k][p] > e_n));
        chk($sformatf("d%0d.p%0d.ack", k, p), 32'(ack_s[k][p]), 32'(ack_m[k][p]));
        chk($sformatf("d%0d.p%0d.err", k, p), 32'(err_s[k][p]), 32'(err_m[k][p]));
        chk($sformatf("d%0d.p%0d.rdata", k, p), rd_s[k][p], rd_m[k][p]);
      end
  endtask

  task automatic tick();
    model_edge(e_n + 1);
    @(posedge clk);
    e_n++;
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic p0_pulse(input logic we, input logic [31:0] a, input logic [31:0] d);
    p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d;
    tick();
    p0_req = 1'b0; p0_we = 1'b0;
  endtask

  task automatic p1_pulse(input logic [31:0] a);
    p1_req = 1'b1; p1_addr = a;
    tick();
    p1_req = 1'b0;
  endtask

  // Cycles from the accept edge until port-0 ack of instance k (cycle 1 is
  // the one right after the accept edge); bounded at 20.
  task automatic wait_ack0(input int k, output int n);
    n = 1;
    while (!ack_s[k][0] && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, acks;

    // Asynchronous reset: outputs clear before any clock edge.
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Give every modelled word a known value.
    for (int s = 0; s < 32; s++) begin
      p0_pulse(1'b1, slot_addr(s), $urandom);
      idle(4);
    end
    p0_pulse(1'b1, 32'h1008, 32'h11);
    idle(4);

    // Write then read with P0_WAIT=1.
    p0_pulse(1'b1, 32'h1000, 32'hDEADBEEF);
    wait_ack0(0, n);
    chk("wr_latency", n, 2);
    chk("wr_err", 32'(err_s[0][0]), 0);
    idle(4);
    p0_pulse(1'b0, 32'h1000, 32'h0);
    wait_ack0(0, n);
    chk("rd_latency", n, 2);
    chk("rd_data", rd_s[0][0], 32'hDEADBEEF);
    chk("rd_err", 32'(err_s[0][0]), 0);
    idle(6);

    // Zero-wait port 1: back-to-back acks with busy low throughout.
    p1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p1_addr = 32'h1000 + 32'(i);
      tick();
      chk($sformatf("b2b_ack%0d", i), 32'(ack_s[0][1]), 1);
      chk($sformatf("b2b_busy%0d", i), 32'(busy_s[0][1]), 0);
    end
    p1_req = 1'b0;
    idle(7);

    // Same-edge p0 write / p1 read collision on instance 0.
    p0_pulse(1'b1, 32'h1004, 32'h7);
    idle(5);
    p0_pulse(1'b1, 32'h1004, 32'h5);
    p1_pulse(32'h1004);
    chk("collide_old", rd_s[0][1], 32'h7);
    idle(7);
    p1_pulse(32'h1004);
    idle(6);
    chk("collide_new", rd_s[0][1], 32'h5);

    // Out-of-range accesses, including an address that aliases 'h1000.
    p0_pulse(1'b0, 32'h0FFF, 32'h0);
    wait_ack0(0, n);
    chk("oor_lo_err", 32'(err_s[0][0]), 1);
    chk("oor_lo_rdata", rd_s[0][0], 0);
    idle(4);
    p0_pulse(1'b0, 32'h2000, 32'h0);
    wait_ack0(0, n);
    chk("oor_hi_err", 32'(err_s[0][0]), 1);
    chk("oor_hi_rdata", rd_s[0][0], 0);
    idle(4);
    p0_pulse(1'b1, 32'h2000, 32'hBAD0BAD0);
    idle(5);
    p0_pulse(1'b0, 32'h1000, 32'h0);
    wait_ack0(0, n);
    chk("oor_store_kept", rd_s[0][0], 32'hDEADBEEF);
    idle(4);
    p0_pulse(1'b0, 32'h1FFF, 32'h0);
    wait_ack0(0, n);
    chk("last_word_err", 32'(err_s[0][0]), 0);
    idle(5);

    // Reset two cycles into a P0_WAIT=3 write.
    p0_pulse(1'b1, 32'h1008, 32'h9);
    idle(1);
    chk("pre_rst_busy", 32'(busy_s[2][0]), 1);
    rst_n = 1'b0;
    #1 model_reset();
    chk("rst_busy_now", 32'(busy_s[2][0]), 0);
    check_all();
    idle(2);
    rst_n = 1'b1;
    idle(1);
    p0_pulse(1'b0, 32'h1008, 32'h0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack_s[2][0]) acks++;
    end
    chk("rst_drop_write", rd_s[2][0], 32'h11);
    chk("rst_read_acks", acks, 1);

    // One-cycle request pulse with P0_WAIT=2: a single ack in cycle 3.
    p0_pulse(1'b0, 32'h1003, 32'h0);
    wait_ack0(1, n);
    chk("pulse_latency", n, 3);
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ack_s[1][0]) acks++;
    end
    chk("pulse_extra_acks", acks, 0);

    // Random traffic on both ports.
    for (int i = 0; i < 400; i++) begin
      p0_req   = 1'($urandom_range(0, 1));
      p0_we    = 1'($urandom_range(0, 1));
      p0_addr  = rand_addr();
      p0_wdata = $urandom;
      p1_req   = 1'($urandom_range(0, 1));
      p1_addr  = rand_addr();
      tick();
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
